// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
// Merges two byte sources into framed writes on a serial TX FIFO.
// Source A is a tape byte stream: its frames end at BURST_MAX bytes or as
// soon as A has nothing to offer while the FIFO has room.
// Source B is a status message: its frames end on the byte flagged by i_b_last.
// Every frame starts with a header byte (HDR_A or HDR_B). Ties in IDLE alternate
// between the sources.
// Optional build macro TX_FRAME_CHECKSUM_EN appends an XOR checksum of the
// payload to every frame.
//
// Ports:
//   i_clock, i_reset           single clock, synchronous active-high reset
//   i_a_data/i_a_valid/o_a_ready             source A stream
//   i_b_data/i_b_valid/i_b_last/o_b_ready    source B message
//   o_fifo_data/o_fifo_write_req/i_fifo_full TX FIFO write side
//   o_busy                     frame in progress (any state but IDLE)
//   o_owner                    source of the current/last frame (0 = A, 1 = B)
module tx_frame_arbiter #(
  parameter int unsigned BURST_MAX = 64,
  parameter logic [7:0]  HDR_A     = 8'hA5,
  parameter logic [7:0]  HDR_B     = 8'h5A
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_a_data,
  input  logic       i_a_valid,
  output logic       o_a_ready,
  input  logic [7:0] i_b_data,
  input  logic       i_b_valid,
  input  logic       i_b_last,
  output logic       o_b_ready,
  output logic [7:0] o_fifo_data,
  output logic       o_fifo_write_req,
  input  logic       i_fifo_full,
  output logic       o_busy,
  output logic       o_owner
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StPayA = 3'd2;
  localparam logic [2:0] StPayB = 3'd3;
  localparam logic [2:0] StChk  = 3'd4;

`ifdef TX_FRAME_CHECKSUM_EN
  localparam logic [2:0] StEnd = StChk;
`else
  localparam logic [2:0] StEnd = StIdle;
`endif

  localparam logic [7:0] BurstMax = BURST_MAX[7:0];

  logic [2:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;  // 1 = B was granted last
  logic [7:0] cnt_q, cnt_d;

  logic       wr;
  logic [7:0] wr_data;
  logic       a_rdy;
  logic       b_rdy;
  logic       grant;

`ifdef TX_FRAME_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr           = 1'b0;
    wr_data      = 8'h00;
    a_rdy        = 1'b0;
    b_rdy        = 1'b0;
    grant        = 1'b0;
`ifdef TX_FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      StIdle: begin
        if (i_a_valid || i_b_valid) begin
          // On a tie, serve whoever was not served last
          grant        = (i_a_valid && i_b_valid) ? ~last_grant_q : i_b_valid;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = StHdr;
        end
      end

      StHdr: begin
        if (!i_fifo_full) begin
          wr      = 1'b1;
          wr_data = owner_q ? HDR_B : HDR_A;
          state_d = owner_q ? StPayB : StPayA;
          cnt_d   = 8'd0;
`ifdef TX_FRAME_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      StPayA: begin
        a_rdy = ~i_fifo_full;
        if (!i_fifo_full) begin
          if (i_a_valid) begin
            wr      = 1'b1;
            wr_data = i_a_data;
            cnt_d   = cnt_q + 8'd1;
`ifdef TX_FRAME_CHECKSUM_EN
            csum_d  = csum_q ^ i_a_data;
`endif
            if (cnt_q + 8'd1 == BurstMax) state_d = StEnd;
          end else begin
            // A has nothing to send while the FIFO has room: close the frame
            state_d = StEnd;
          end
        end
      end

      StPayB: begin
        b_rdy = ~i_fifo_full;
        if (!i_fifo_full && i_b_valid) begin
          wr      = 1'b1;
          wr_data = i_b_data;
`ifdef TX_FRAME_CHECKSUM_EN
          csum_d  = csum_q ^ i_b_data;
`endif
          if (i_b_last) state_d = StEnd;
        end
      end

`ifdef TX_FRAME_CHECKSUM_EN
      StChk: begin
        if (!i_fifo_full) begin
          wr      = 1'b1;
          wr_data = csum_q;
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
`ifdef TX_FRAME_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
`ifdef TX_FRAME_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Reset masks all handshakes so an abandoned frame leaves no trailing write
  assign o_fifo_write_req = wr & ~i_reset;
  assign o_fifo_data      = i_reset ? 8'h00 : wr_data;
  assign o_a_ready        = a_rdy & ~i_reset;
  assign o_b_ready        = b_rdy & ~i_reset;
  assign o_busy           = (state_q != StIdle);
  assign o_owner          = owner_q;

endmodule
